// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: the CPU MEM stage owns the single memory port,
// and a DMA/debug requester is forced through after MAX_WAIT lost cycles.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  // MEM stage side
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  // DMA / debug side
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic        dma_err,
  output logic [31:0] dma_rdata,
  // Data memory side
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned DW = 32;
  localparam logic [WAIT_W-1:0] WaitLimit = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WaitSat   = {WAIT_W{1'b1}};

  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [DW-1:0]     rdata_q, rdata_d;

  logic cpu_active;
  logic mis;
  logic dma_valid;
  logic dma_grant;
  logic err_path;

  // Request qualification; a request is ignored during its own ack cycle
  always_comb begin
    cpu_active = cpu_mem_read | cpu_mem_write;
    mis        = |dma_addr[1:0];
    dma_valid  = dma_req & ~ack_q;
    err_path   = dma_valid & mis;
    dma_grant  = dma_valid & ~mis & (~cpu_active | (wait_q >= WaitLimit));
  end

  // Memory port mux and CPU-facing results
  always_comb begin
    mem_read  = cpu_mem_read;
    mem_write = cpu_mem_write;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    cpu_rdata = '0;
    cpu_stall = dma_grant & cpu_active;
    if (dma_grant) begin
      mem_read  = ~dma_we;
      mem_write = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else if (cpu_mem_read) begin
      cpu_rdata = mem_rdata;
    end
  end

  // Starvation counter: counts cycles an aligned request has lost to the CPU
  always_comb begin
    wait_d = wait_q;
    if (~dma_req | dma_grant | err_path) begin
      wait_d = '0;
    end else if (dma_valid & ~mis) begin
      wait_d = (wait_q == WaitSat) ? wait_q : wait_q + WAIT_W'(1);
    end
  end

  // Completion bookkeeping for the DMA requester
  always_comb begin
    ack_d   = dma_grant | err_path;
    err_d   = err_path;
    rdata_d = rdata_q;
    if (dma_grant & ~dma_we) begin
      rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      wait_q  <= '0;
      rdata_q <= '0;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
    end
  end

  assign dma_ack   = ack_q;
  assign dma_err   = err_q;
  assign dma_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by a randomized run
// checked against a transaction-level model of the CPU/DMA sharing rules.
module tb_dmem_arbiter;

  localparam int unsigned MAXW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_mem_read, cpu_mem_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_ack, dma_err;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(MAXW), .WAIT_W(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_err(dma_err),
    .dma_rdata(dma_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory instance: combinational read, write on the clock edge
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // model state for the randomized phase
    logic        m_ack, m_err, m_busy, stall_prev;
    int          m_lost;
    logic [31:0] m_rdata;

    for (int i = 0; i < 256; i++) mem[i] = 32'h5A00_0000 + 32'(i * 7);
    mem[1] = 32'h0000_41A8;

    reset = 1'b1;
    cpu_mem_read = 0; cpu_mem_write = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;

    // reset state
    next_cycle(); #2;
    chk("rst_ack", 32'(dma_ack), 0);
    chk("rst_err", 32'(dma_err), 0);
    chk("rst_rdata", dma_rdata, 0);
    chk("rst_stall", 32'(cpu_stall), 0);
    next_cycle(); reset = 1'b0; #2;
    chk("post_rst_ack", 32'(dma_ack), 0);

    // DMA write with CPU idle: grant in T, ack in T+1
    next_cycle();
    dma_req = 1; dma_we = 1; dma_addr = 32'h10; dma_wdata = 32'hDEAD_BEEF; #2;
    chk("w_memwrite", 32'(mem_write), 1);
    chk("w_memread", 32'(mem_read), 0);
    chk("w_addr", mem_addr, 32'h10);
    chk("w_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("w_ack_T", 32'(dma_ack), 0);
    next_cycle(); dma_req = 0; #2;
    chk("w_ack_T1", 32'(dma_ack), 1);
    chk("w_err_T1", 32'(dma_err), 0);
    next_cycle(); cpu_mem_read = 1; cpu_addr = 32'h10; #2;
    chk("w_cpu_readback", cpu_rdata, 32'hDEAD_BEEF);

    // starvation: CPU reads continuously, DMA read forced on the 5th cycle
    next_cycle();
    cpu_addr = 32'h04; dma_req = 1; dma_we = 0; dma_addr = 32'h04;
    for (int k = 0; k < int'(MAXW); k++) begin
      #2;
      chk("starve_stall0", 32'(cpu_stall), 0);
      chk("starve_cpu_rdata", cpu_rdata, 32'h0000_41A8);
      next_cycle();
    end
    #2;
    chk("starve_stall1", 32'(cpu_stall), 1);
    chk("starve_cpu_rdata0", cpu_rdata, 0);
    chk("starve_memaddr", mem_addr, 32'h04);
    next_cycle(); dma_req = 0; #2;
    chk("starve_ack", 32'(dma_ack), 1);
    chk("starve_dma_rdata", dma_rdata, 32'h0000_41A8);
    chk("starve_stall_after", 32'(cpu_stall), 0);
    chk("starve_cpu_done", cpu_rdata, 32'h0000_41A8);

    // back-to-back reads with dma_req held through the ack cycle
    next_cycle();
    cpu_mem_read = 0; cpu_addr = '0; dma_req = 1; dma_we = 0; dma_addr = 32'h04; #2;
    chk("b2b_grant1", 32'(mem_read), 1);
    chk("b2b_ack_first", 32'(dma_ack), 0);
    next_cycle(); #2;
    chk("b2b_ack1", 32'(dma_ack), 1);
    chk("b2b_nogrant1", 32'(mem_read), 0);
    next_cycle(); dma_addr = 32'h10; #2;
    chk("b2b_ack_gap", 32'(dma_ack), 0);
    chk("b2b_grant2", 32'(mem_read), 1);
    chk("b2b_addr2", mem_addr, 32'h10);
    next_cycle(); #2;
    chk("b2b_ack2", 32'(dma_ack), 1);
    chk("b2b_nogrant2", 32'(mem_read), 0);
    chk("b2b_rdata2", dma_rdata, 32'hDEAD_BEEF);
    next_cycle(); dma_req = 0; #2;
    chk("b2b_no_third", 32'(dma_ack), 0);

    // misaligned DMA read: error ack, memory follows the CPU only
    next_cycle();
    cpu_mem_read = 1; cpu_addr = 32'h10; dma_req = 1; dma_we = 0; dma_addr = 32'h06; #2;
    chk("mis_memread", 32'(mem_read), 1);
    chk("mis_memwrite", 32'(mem_write), 0);
    chk("mis_addr", mem_addr, 32'h10);
    chk("mis_stall", 32'(cpu_stall), 0);
    chk("mis_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
    next_cycle(); dma_req = 0; #2;
    chk("mis_ack", 32'(dma_ack), 1);
    chk("mis_err", 32'(dma_err), 1);
    chk("mis_rdata_kept", dma_rdata, 32'hDEAD_BEEF);

    // same-word write collision on a forced grant
    next_cycle();
    cpu_mem_read = 0; cpu_mem_write = 1; cpu_addr = 32'h20; cpu_wdata = 32'hC0FF_EE00;
    dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'h1234_5678;
    for (int k = 0; k < int'(MAXW); k++) begin
      #2;
      chk("coll_cpu_wdata", mem_wdata, 32'hC0FF_EE00);
      next_cycle();
    end
    #2;
    chk("coll_stall", 32'(cpu_stall), 1);
    chk("coll_dma_wdata", mem_wdata, 32'h1234_5678);
    next_cycle(); dma_req = 0; #2;
    chk("coll_dma_first", mem[8], 32'h1234_5678);
    chk("coll_retry_wdata", mem_wdata, 32'hC0FF_EE00);
    chk("coll_retry_stall", 32'(cpu_stall), 0);
    next_cycle(); cpu_mem_write = 0; #2;
    chk("coll_final", mem[8], 32'hC0FF_EE00);

    // reset while a starved request is pending
    next_cycle();
    cpu_mem_read = 1; cpu_addr = 32'h04; dma_req = 1; dma_we = 0; dma_addr = 32'h10;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("prerst_stall", 32'(cpu_stall), 0);
      next_cycle();
    end
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #2;
      chk("midrst_ack", 32'(dma_ack), 0);
      chk("midrst_err", 32'(dma_err), 0);
      chk("midrst_rdata", dma_rdata, 0);
      chk("midrst_stall", 32'(cpu_stall), 0);
      next_cycle();
    end
    reset = 1'b0;
    for (int k = 0; k < int'(MAXW); k++) begin
      #2;
      chk("postrst_stall0", 32'(cpu_stall), 0);
      chk("postrst_ack0", 32'(dma_ack), 0);
      next_cycle();
    end
    #2;
    chk("postrst_stall1", 32'(cpu_stall), 1);
    next_cycle(); dma_req = 0; #2;
    chk("postrst_ack", 32'(dma_ack), 1);
    chk("postrst_rdata", dma_rdata, 32'hDEAD_BEEF);

    // randomized phase against a transaction-level model
    next_cycle();
    cpu_mem_read = 0; cpu_mem_write = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    m_ack = 0; m_err = 0; m_lost = 0; m_rdata = 32'hDEAD_BEEF;
    m_busy = 0; stall_prev = 0;

    for (int n = 0; n < 600; n++) begin
      logic        live, bad, served, exp_stall, cpu_act;
      logic [31:0] exp_addr, exp_wdata, exp_crd;
      logic [7:0]  d_idx, c_idx;

      if (!stall_prev) begin
        int op = $urandom_range(0, 9);
        cpu_mem_read  = (op >= 3 && op <= 6);
        cpu_mem_write = (op >= 7);
        cpu_addr      = 32'($urandom_range(0, 15)) << 2;
        cpu_wdata     = $urandom;
      end
      if (m_busy && m_ack) m_busy = 0;
      if (!m_busy) begin
        if ($urandom_range(0, 2) != 0) begin
          m_busy    = 1;
          dma_req   = 1;
          dma_we    = 1'($urandom_range(0, 1));
          dma_addr  = (32'($urandom_range(0, 15)) << 2) |
                      (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
          dma_wdata = $urandom;
        end else begin
          dma_req = 0;
        end
      end
      #2;

      cpu_act   = cpu_mem_read | cpu_mem_write;
      live      = dma_req && !m_ack;
      bad       = live && (dma_addr[1:0] != 2'b00);
      served    = live && !bad && (!cpu_act || m_lost >= int'(MAXW));
      exp_stall = served && cpu_act;
      exp_addr  = served ? dma_addr : cpu_addr;
      exp_wdata = served ? dma_wdata : cpu_wdata;
      c_idx     = cpu_addr[9:2];
      d_idx     = dma_addr[9:2];
      exp_crd   = (!served && cpu_mem_read) ? ref_mem[c_idx] : 32'd0;

      chk("rnd_stall", 32'(cpu_stall), 32'(exp_stall));
      chk("rnd_mem_read", 32'(mem_read), 32'(served ? !dma_we : cpu_mem_read));
      chk("rnd_mem_write", 32'(mem_write), 32'(served ? dma_we : cpu_mem_write));
      chk("rnd_mem_addr", mem_addr, exp_addr);
      chk("rnd_mem_wdata", mem_wdata, exp_wdata);
      chk("rnd_cpu_rdata", cpu_rdata, exp_crd);
      chk("rnd_ack", 32'(dma_ack), 32'(m_ack));
      chk("rnd_err", 32'(dma_err), 32'(m_err));
      chk("rnd_dma_rdata", dma_rdata, m_rdata);

      if (served && !dma_we) m_rdata = ref_mem[d_idx];
      if (served && dma_we) ref_mem[d_idx] = dma_wdata;
      else if (!served && cpu_mem_write) ref_mem[c_idx] = cpu_wdata;
      if (!dma_req || served || bad) m_lost = 0;
      else if (live) m_lost = (m_lost < 255) ? m_lost + 1 : 255;
      m_ack      = served || bad;
      m_err      = bad;
      stall_prev = exp_stall;
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter in front of the single-port data memory (256 x 32, combinational read, write on clock edge). Requesters are the pipeline MEM stage (CPU, normally highest priority) and a secondary DMA/debug port. The CPU never waits unless the DMA requester has been starved for `MAX_WAIT` cycles. When that happens, the DMA access takes the port for one cycle and the CPU is stalled. Sits between the MEM stage and the data memory instance.

## Interface
- `MAX_WAIT`, 4: cycles a pending DMA request may lose to the CPU before it is forced through; legal range 1..255.
- `WAIT_W`, 8: width of the starvation counter.

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `cpu_mem_read` in 1: MEM stage read request.
- `cpu_mem_write` in 1: MEM stage write request.
- `cpu_addr` in 32: CPU byte address.
- `cpu_wdata` in 32: CPU write data.
- `cpu_rdata` out 32: CPU read data.
- `cpu_stall` out 1: hold MEM stage this cycle.
- `dma_req` in 1: DMA request; held with `dma_we`/`dma_addr`/`dma_wdata` stable until `dma_ack`.
- `dma_we` in 1: 1 = write, 0 = read.
- `dma_addr` in 32: DMA byte address.
- `dma_wdata` in 32: DMA write data.
- `dma_ack` out 1: one-cycle completion pulse.
- `dma_err` out 1: valid with `dma_ack`; misaligned request, no memory access.
- `dma_rdata` out 32: registered read data, valid with `dma_ack`.
- `mem_read`, `mem_write` out 1: to data memory `MemRead`/`MemWrite`.
- `mem_addr`, `mem_wdata` out 32: to data memory.
- `mem_rdata` in 32: from data memory.

## Operation
- Definitions:
  - `cpu_active = cpu_mem_read | cpu_mem_write`.
  - `mis = dma_addr[1:0] != 0`.
  - `dma_valid = dma_req & !ack_q`. A request is never re-issued in its own ack cycle.
- Error path: `dma_valid & mis` completes without a grant. Memory is untouched, the CPU is not stalled, and the next cycle gives `ack_q=1`, `err_q=1`, `rdata_q` unchanged.
- Grant (combinational): `dma_grant = dma_valid & !mis & (!cpu_active | wait_cnt >= MAX_WAIT)`.
- Port mux:
  - When `dma_grant=1`, the DMA fields drive `mem_*`: `mem_read = !dma_we`, `mem_write = dma_we`.
  - Otherwise the CPU fields drive `mem_*` unchanged.
- `cpu_stall = dma_grant & cpu_active`.
- `cpu_rdata`:
  - `mem_rdata` when `!dma_grant & cpu_mem_read`, else 0.
  - A stalled CPU gets 0 and retries next cycle with the same request.
- Starvation counter `wait_cnt`, at each clock edge:
  - Cleared if `!dma_req`, `dma_grant`, or the error path is taken.
  - Saturating increment if `dma_valid & !mis & !dma_grant`.
  - Held otherwise.
- Completion registers, at each clock edge:
  - `ack_q <= dma_grant | (dma_valid & mis)`.
  - `err_q <= dma_valid & mis`.
  - `rdata_q <= mem_rdata` when `dma_grant & !dma_we`.
- Output mapping: `dma_ack = ack_q`, `dma_err = err_q`, `dma_rdata = rdata_q`.
- Simultaneous CPU write and DMA write to the same word on a forced grant: the DMA write lands first; the stalled CPU write lands the next cycle.

## Timing
- Reset values: `ack_q`, `err_q`, `wait_cnt` and `rdata_q` are all 0. All registered outputs are therefore 0 during reset and one cycle after it.
- Reset mid-request drops the request. No ack is produced for it; the requester must re-issue.
- DMA latency with the CPU idle: grant in cycle T (write commits at the edge ending T), `dma_ack` in T+1.
- DMA latency with the CPU continuously active: `wait_cnt` steps 0..`MAX_WAIT`, and the grant occurs in the `MAX_WAIT+1`-th cycle of the request.
- `cpu_stall` is high for exactly one cycle per forced grant.
- Ack cycle: no grant is possible, so the CPU always proceeds. Maximum DMA throughput is one access per 2 cycles.
- The CPU path is purely combinational, adding zero latency when not stalled.

## Test plan
- CPU idle; DMA write 0xDEADBEEF to 0x10 -> `mem_write=1`, `mem_addr=0x10` in cycle T; `dma_ack=1`, `dma_err=0` in T+1. A subsequent CPU read of 0x10 returns 0xDEADBEEF.
- CPU reading continuously; DMA read of 0x04 (word = 0x000041A8), `MAX_WAIT=4` -> `cpu_stall=0` for 4 cycles; in cycle 5 `cpu_stall=1` and `cpu_rdata=0`; next cycle `dma_ack=1`, `dma_rdata=0x000041A8`, and the CPU read completes.
- DMA holds `dma_req` through its ack, then issues a second read -> exactly two acks, no grant in either ack cycle, at least 2 cycles between acks.
- DMA read of address 0x06 -> `dma_ack=1`, `dma_err=1` one cycle later; `mem_read`/`mem_write` follow the CPU only; `cpu_stall` stays 0; `dma_rdata` unchanged.
- CPU write and DMA write (forced grant) both to 0x20 -> DMA data written first, CPU data written the next cycle; final word = CPU data.
- Assert `reset` in a cycle where `wait_cnt=3` with `dma_req` high -> no ack; `wait_cnt=0`; all outputs 0 while reset is high; normal arbitration resumes after release.
